// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared codes for the RV32M multiply/divide unit.
// funct3 operation codes, the R-type opcode / funct7 marker the control unit
// uses to gate start, and the sequencing FSM state type.
`timescale 1ns/1ps
package muldiv_unit_pkg;

    // funct3 codes of the M-extension operations
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    // Decode markers: start is only raised for opcode==R_TYPE with funct7==FUNCT7_MULDIV
    localparam logic [6:0] R_TYPE        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit_div_restoring_step.sv
// div_restoring_step: one combinational iteration of restoring division.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor and produces the quotient bit plus the restored/updated remainder.
`timescale 1ns/1ps
module div_restoring_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;

    // Partial remainder < divisor, so the shifted value is < 2*divisor and the
    // difference always fits XLEN bits; the carry-out bit only feeds the compare.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift[XLEN-1:0] - i_divisor;
        o_qbit  = w_shift[XLEN] | (w_shift[XLEN-1:0] >= i_divisor);
        o_rem   = o_qbit ? w_diff : w_shift[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with sequencing FSM.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiply instead of
// the 32-cycle shift-add sequence (divide is iterative in both builds).
`timescale 1ns/1ps
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_a_neg;
    logic              r_b_neg;
    logic [XLEN-1:0]   r_a_mag;
    logic [XLEN-1:0]   r_b_mag;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special_res;

    logic [XLEN-1:0]   w_rem_next;
    logic              w_qbit;
    logic [XLEN-1:0]   w_quot_next;
    logic [XLEN-1:0]   w_q_final;
    logic [XLEN-1:0]   w_r_final;
    logic [XLEN-1:0]   w_div_res;

    // Operand decode at issue: signedness per op, magnitudes and divide short-cuts
    always_comb begin
        w_a_signed = (funct3 == MULDIV_MUL) | (funct3 == MULDIV_MULH) |
                     (funct3 == MULDIV_MULHSU) | (funct3 == MULDIV_DIV) |
                     (funct3 == MULDIV_REM);
        w_b_signed = (funct3 == MULDIV_MUL) | (funct3 == MULDIV_MULH) |
                     (funct3 == MULDIV_DIV) | (funct3 == MULDIV_REM);
        w_a_neg    = w_a_signed & op_a[XLEN-1];
        w_b_neg    = w_b_signed & op_b[XLEN-1];
        w_a_mag    = w_a_neg ? -op_a : op_a;
        w_b_mag    = w_b_neg ? -op_b : op_b;
        w_div_zero = (op_b == '0);
        w_div_ovf  = ((funct3 == MULDIV_DIV) | (funct3 == MULDIV_REM)) &
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        if (w_div_zero) begin
            w_special_res = ((funct3 == MULDIV_DIV) | (funct3 == MULDIV_DIVU)) ? '1 : op_a;
        end else begin
            w_special_res = (funct3 == MULDIV_DIV) ? op_a : '0;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN+1:0] w_fprod;
    logic [XLEN-1:0]          w_fast_res;

    // Single-cycle product on sign-extended operands, word selected by op
    always_comb begin
        w_fa       = {w_a_signed & op_a[XLEN-1], op_a};
        w_fb       = {w_b_signed & op_b[XLEN-1], op_b};
        w_fprod    = w_fa * w_fb;
        w_fast_res = (funct3 == MULDIV_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    end
`else
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // Shift-add step: multiplier sits in the low half and shifts out as the product grows
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a_mag : '0)};
        w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_prod     = (r_a_neg ^ r_b_neg) ? -w_acc_next : w_acc_next;
        w_mul_res  = (r_op == MULDIV_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
`endif

    div_restoring_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[XLEN-1]),
        .i_divisor (r_b_mag),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // Divide finish: sign-fix quotient/remainder from the final iteration
    always_comb begin
        w_quot_next = {r_quot[XLEN-2:0], w_qbit};
        w_q_final   = (r_a_neg ^ r_b_neg) ? -w_quot_next : w_quot_next;
        w_r_final   = r_a_neg ? -w_rem_next : w_rem_next;
        w_div_res   = ((r_op == MULDIV_REM) | (r_op == MULDIV_REMU)) ? w_r_final : w_q_final;
    end

    // Sequencing FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
`ifndef MULDIV_FAST_MUL_EN
            r_acc    <= '0;
`endif
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= funct3;
                        r_a_neg <= w_a_neg;
                        r_b_neg <= w_b_neg;
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_cnt   <= '0;
                        if (!funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
`else
                            r_acc   <= {{XLEN{1'b0}}, w_b_mag};
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
`endif
                        end else if (w_div_zero | w_div_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quot  <= w_a_mag;
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV;
                        end
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                ST_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_result <= w_mul_res;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
`endif
                ST_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_result <= w_div_res;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive; stall also covers the issue cycle before busy rises
    always_comb begin
        busy   = r_busy;
        done   = r_done;
        result = r_result;
        stall  = r_busy | (start & (r_state == ST_IDLE));
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (honours MULDIV_FAST_MUL_EN).
`timescale 1ns/1ps
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    logic [31:0] last_result = '0;
    exp_t        sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference result from native wide/signed arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic [63:0]        ua64;
        logic [63:0]        ub64;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] sq;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        sa = a;
        sbv = b;
        case (f3)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                sq = sa / sbv; return sq;
            end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                sq = sa % sbv; return sq;
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Cycle in which done is expected, counting the accepting edge as edge 0
    function automatic int unsigned model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string tag);
        exp_t        e;
        int unsigned cyc;
        logic        got;
        logic        busy_ok;
        e.res = exp_res;
        e.lat = model_lat(f3, a, b);
        sb.push_back(e);
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1;
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_c0: got %b exp 1", tag, stall); end
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== (cyc < e.lat)) busy_ok = 1'b0;
        end
        e = sb.pop_front();
        last_result = e.res;
        n_chk++;
        if (!busy_ok) begin n_fail++; $display("FAIL %s busy_profile: got mismatch exp busy in cycles 1..%0d", tag, e.lat - 1); end
        n_chk++;
        if (!got) begin
            n_fail++; $display("FAIL %s timeout: got no done exp done in cycle %0d", tag, e.lat);
        end else begin
            if (result !== e.res) begin n_fail++; $display("FAIL %s result: got %h exp %h", tag, result, e.res); end
            n_chk++;
            if (cyc != e.lat) begin n_fail++; $display("FAIL %s latency: got %0d exp %0d", tag, cyc, e.lat); end
            n_chk++;
            if (stall !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL %s done_cycle_stall_busy: got %b%b exp 00", tag, stall, busy);
            end
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse_width: got %b exp 0", tag, done); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, stall} !== 3'b000 || result !== 32'd0) begin
            n_fail++; $display("FAIL reset_state: got busy=%b done=%b stall=%b result=%h exp 0 0 0 0", busy, done, stall, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, "mulhu");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, "mulh_m1");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        run_op(3'd5, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, "divu_max");
    endtask

    task automatic test_div_special();
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
    endtask

    task automatic test_flush();
        logic saw_done;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "flush_pre");
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        if (done === 1'b1) saw_done = 1'b1;
        n_chk++;
        if (busy !== 1'b0 || saw_done) begin
            n_fail++; $display("FAIL flush_idle: got busy=%b saw_done=%b exp 0 0", busy, saw_done);
        end
        n_chk++;
        if (result !== last_result) begin n_fail++; $display("FAIL flush_result_hold: got %h exp %h", result, last_result); end
        run_op(3'd4, 32'd1000, 32'd3, 32'd333, "post_flush_div");
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; flush = 1'b1; start = 1'b1; funct3 = 3'd5; op_b = 32'd0;
        @(posedge clk); #1;
        n_chk++;
        if ({busy, done} !== 2'b00 || result !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid: got busy=%b done=%b result=%h exp 0 0 0", busy, done, result);
        end
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b exp 0", stall); end
        last_result = 32'd0;
        run_op(3'd0, 32'd123, 32'd456, 32'd56088, "post_rst_mul");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(f3, a, b, model_res(f3, a, b), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
